// File: rtl/alu_operand_sequencer_if.sv
// Switch/button bundle between the board inputs and the operand sequencer,
// plus the operand set presented to the ALU.
interface alu_operand_sequencer_if;
    logic [5:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] fxn;
    logic       op_valid;
    logic       op_start;
    logic [1:0] stage;

    modport master (output sw, btn_enter, btn_clear,
                    input  a, b, fxn, op_valid, op_start, stage);
    modport slave  (input  sw, btn_enter, btn_clear,
                    output a, b, fxn, op_valid, op_start, stage);
endinterface

// File: rtl/alu_operand_sequencer.sv
// Debounced operand entry for the 6-bit ALU: A, then B, then function code.
// Optional OPSEQ_LIVE_PREVIEW_EN: the field being entered tracks sw live.
module opseq_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Level flips only after the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_sequencer_if.slave  bus
);
    localparam int NUM_BTN = 2;

    typedef enum logic [1:0] {
        LOAD_A   = 2'b00,
        LOAD_B   = 2'b01,
        LOAD_FXN = 2'b10,
        READY    = 2'b11
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;
    logic               ent;
    logic               clr;

    assign btn_raw = {bus.btn_clear, bus.btn_enter};
    assign ent     = press[0];
    assign clr     = press[1];

    opseq_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db [NUM_BTN-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw),
        .press (press)
    );

    state_t     state;
    logic [5:0] a_q;
    logic [5:0] b_q;
    logic [2:0] fxn_q;
    logic       op_valid_q;
    logic       op_start_q;

    // Clear is checked first so a coincident enter is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            a_q        <= '0;
            b_q        <= '0;
            fxn_q      <= '0;
            op_valid_q <= 1'b0;
            op_start_q <= 1'b0;
        end else begin
            op_start_q <= 1'b0;
            if (clr) begin
                state      <= LOAD_A;
                a_q        <= '0;
                b_q        <= '0;
                fxn_q      <= '0;
                op_valid_q <= 1'b0;
            end else if (ent) begin
                case (state)
                    LOAD_A: begin
                        a_q   <= bus.sw;
                        state <= LOAD_B;
                    end
                    LOAD_B: begin
                        b_q   <= bus.sw;
                        state <= LOAD_FXN;
                    end
                    LOAD_FXN: begin
                        fxn_q      <= bus.sw[2:0];
                        state      <= READY;
                        op_valid_q <= 1'b1;
                        op_start_q <= 1'b1;
                    end
                    default: begin
                        state      <= LOAD_A;
                        op_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef OPSEQ_LIVE_PREVIEW_EN
    assign bus.a   = (state == LOAD_A)   ? bus.sw      : a_q;
    assign bus.b   = (state == LOAD_B)   ? bus.sw      : b_q;
    assign bus.fxn = (state == LOAD_FXN) ? bus.sw[2:0] : fxn_q;
`else
    assign bus.a   = a_q;
    assign bus.b   = b_q;
    assign bus.fxn = fxn_q;
`endif
    assign bus.op_valid = op_valid_q;
    assign bus.op_start = op_start_q;
    assign bus.stage    = state;
endmodule
